// File: rtl/alu_issue_queue.sv
// ALU reservation station with 4 entries, result-broadcast wakeup, and select-and-issue; ALU_ISQ_AGE_SELECT_EN picks the oldest eligible entry instead of the lowest index.
// Latency: an entry with ready operands issues in the cycle after dispatch; a broadcast-woken entry issues in the cycle after the broadcast.
// Backpressure: the selected entry is held while alu_iss_ready=0; disp_ready is low when all entries are full.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [2:0]       disp_ctrl,
    input  logic [TAG_W-1:0] disp_rob_num,
    input  logic             disp_src1_rdy,
    input  logic             disp_src2_rdy,
    input  logic [TAG_W-1:0] disp_src1_tag,
    input  logic [TAG_W-1:0] disp_src2_tag,
    input  logic [31:0]      disp_src1_val,
    input  logic [31:0]      disp_src2_val,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [31:0]      wb_data,
    output logic [66:0]      alu_data,
    output logic [TAG_W-1:0] alu_rob_num,
    output logic             alu_iss,
    input  logic             alu_iss_ready,
    output logic [2:0]       occupancy
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d, s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
    logic [2:0]       ctrl_q   [DEPTH];
    logic [2:0]       ctrl_d   [DEPTH];
    logic [TAG_W-1:0] rob_q    [DEPTH];
    logic [TAG_W-1:0] rob_d    [DEPTH];
    logic [TAG_W-1:0] s1_tag_q [DEPTH];
    logic [TAG_W-1:0] s1_tag_d [DEPTH];
    logic [TAG_W-1:0] s2_tag_q [DEPTH];
    logic [TAG_W-1:0] s2_tag_d [DEPTH];
    logic [31:0]      s1_val_q [DEPTH];
    logic [31:0]      s1_val_d [DEPTH];
    logic [31:0]      s2_val_q [DEPTH];
    logic [31:0]      s2_val_d [DEPTH];
    logic [2:0]       occ_q, occ_d;
`ifdef ALU_ISQ_AGE_SELECT_EN
    // age_q[j][i] set means entry j was dispatched before entry i
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
    logic             older_elig;
`endif

    logic [DEPTH-1:0] eligible;
    logic             any_elig, free_found, disp_fire, iss_fire;
    logic [IDX_W-1:0] sel_idx, free_idx;

    assign disp_ready = (occ_q < 3'd4);
    assign occupancy  = occ_q;
    assign eligible   = valid_q & s1_rdy_q & s2_rdy_q;

    always_comb begin
        any_elig = 1'b0;
        sel_idx  = '0;
`ifdef ALU_ISQ_AGE_SELECT_EN
        older_elig = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            older_elig = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && eligible[j] && age_q[j][i]) older_elig = 1'b1;
            end
            if (eligible[i] && !older_elig && !any_elig) begin
                any_elig = 1'b1;
                sel_idx  = IDX_W'(i);
            end
        end
`else
        for (int i = 0; i < DEPTH; i++) begin
            if (eligible[i] && !any_elig) begin
                any_elig = 1'b1;
                sel_idx  = IDX_W'(i);
            end
        end
`endif
        alu_iss     = any_elig && !flush;
        alu_data    = alu_iss ? {ctrl_q[sel_idx], s2_val_q[sel_idx], s1_val_q[sel_idx]} : '0;
        alu_rob_num = alu_iss ? rob_q[sel_idx] : '0;
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        disp_fire = disp_valid && disp_ready && !flush && free_found;
        iss_fire  = alu_iss && alu_iss_ready;

        valid_d  = valid_q;
        s1_rdy_d = s1_rdy_q;
        s2_rdy_d = s2_rdy_q;
        ctrl_d   = ctrl_q;
        rob_d    = rob_q;
        s1_tag_d = s1_tag_q;
        s2_tag_d = s2_tag_q;
        s1_val_d = s1_val_q;
        s2_val_d = s2_val_q;
`ifdef ALU_ISQ_AGE_SELECT_EN
        age_d    = age_q;
`endif

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && wb_valid) begin
                if (!s1_rdy_q[i] && s1_tag_q[i] == wb_tag) begin
                    s1_rdy_d[i] = 1'b1;
                    s1_val_d[i] = wb_data;
                end
                if (!s2_rdy_q[i] && s2_tag_q[i] == wb_tag) begin
                    s2_rdy_d[i] = 1'b1;
                    s2_val_d[i] = wb_data;
                end
            end
        end

        if (iss_fire) valid_d[sel_idx] = 1'b0;

        // The free slot comes from registered valid bits, so it can never be the slot issuing now
        if (disp_fire) begin
            valid_d[free_idx]  = 1'b1;
            ctrl_d[free_idx]   = disp_ctrl;
            rob_d[free_idx]    = disp_rob_num;
            s1_tag_d[free_idx] = disp_src1_tag;
            s2_tag_d[free_idx] = disp_src2_tag;
            s1_rdy_d[free_idx] = disp_src1_rdy || (wb_valid && disp_src1_tag == wb_tag);
            s2_rdy_d[free_idx] = disp_src2_rdy || (wb_valid && disp_src2_tag == wb_tag);
            s1_val_d[free_idx] = disp_src1_rdy ? disp_src1_val : wb_data;
            s2_val_d[free_idx] = disp_src2_rdy ? disp_src2_val : wb_data;
`ifdef ALU_ISQ_AGE_SELECT_EN
            for (int j = 0; j < DEPTH; j++) begin
                age_d[j][free_idx] = 1'b1;
                age_d[free_idx][j] = 1'b0;
            end
`endif
        end

        if (flush) begin
            valid_d = '0;
            occ_d   = '0;
        end else begin
            occ_d = occ_q + {2'b00, disp_fire} - {2'b00, iss_fire};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            s1_rdy_q <= '0;
            s2_rdy_q <= '0;
            ctrl_q   <= '{default: '0};
            rob_q    <= '{default: '0};
            s1_tag_q <= '{default: '0};
            s2_tag_q <= '{default: '0};
            s1_val_q <= '{default: '0};
            s2_val_q <= '{default: '0};
            occ_q    <= '0;
`ifdef ALU_ISQ_AGE_SELECT_EN
            age_q    <= '{default: '0};
`endif
        end else begin
            valid_q  <= valid_d;
            s1_rdy_q <= s1_rdy_d;
            s2_rdy_q <= s2_rdy_d;
            ctrl_q   <= ctrl_d;
            rob_q    <= rob_d;
            s1_tag_q <= s1_tag_d;
            s2_tag_q <= s2_tag_d;
            s1_val_q <= s1_val_d;
            s2_val_q <= s2_val_d;
            occ_q    <= occ_d;
`ifdef ALU_ISQ_AGE_SELECT_EN
            age_q    <= age_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: reset, dispatch/issue, wakeup, full queue, select order, flush.
module tb_alu_issue_queue;
    logic        clk = 1'b0;
    logic        rst_n, flush, disp_valid, disp_ready;
    logic [2:0]  disp_ctrl;
    logic [5:0]  disp_rob_num, disp_src1_tag, disp_src2_tag, wb_tag, alu_rob_num;
    logic        disp_src1_rdy, disp_src2_rdy, wb_valid, alu_iss, alu_iss_ready;
    logic [31:0] disp_src1_val, disp_src2_val, wb_data;
    logic [66:0] alu_data;
    logic [2:0]  occupancy;
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(4), .TAG_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ctrl(disp_ctrl),
        .disp_rob_num(disp_rob_num),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .alu_data(alu_data), .alu_rob_num(alu_rob_num), .alu_iss(alu_iss),
        .alu_iss_ready(alu_iss_ready), .occupancy(occupancy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one dispatch for a single edge, then drops disp_valid.
    task automatic dispatch(input logic [2:0] c, input logic [5:0] rob,
                            input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                            input logic r2, input logic [5:0] t2, input logic [31:0] v2);
        disp_ctrl = c; disp_rob_num = rob;
        disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
        disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
        disp_valid = 1'b1;
        step();
        disp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 0; disp_valid = 0; wb_valid = 0; alu_iss_ready = 0;
        disp_ctrl = 0; disp_rob_num = 0; disp_src1_rdy = 0; disp_src2_rdy = 0;
        disp_src1_tag = 0; disp_src2_tag = 0; disp_src1_val = 0; disp_src2_val = 0;
        wb_tag = 0; wb_data = 0;
        repeat (2) step();
        checks++; if (occupancy !== 3'd0) $display("FAIL reset_occ got %0d exp 0", occupancy); else passed++;
        checks++; if (disp_ready !== 1'b1) $display("FAIL reset_disp_ready got %b exp 1", disp_ready); else passed++;
        checks++; if (alu_iss !== 1'b0) $display("FAIL reset_alu_iss got %b exp 0", alu_iss); else passed++;
        checks++; if (alu_data !== 67'd0 || alu_rob_num !== 6'd0)
            $display("FAIL reset_alu_out got %h/%0d exp 0/0", alu_data, alu_rob_num); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_issue();
        dispatch(3'b010, 6'd5, 1'b1, 6'd0, 32'h11, 1'b1, 6'd0, 32'h22);
        checks++; if (alu_iss !== 1'b1) $display("FAIL basic_iss got %b exp 1", alu_iss); else passed++;
        checks++; if (alu_data !== {3'b010, 32'h22, 32'h11})
            $display("FAIL basic_data got %h exp %h", alu_data, {3'b010, 32'h22, 32'h11}); else passed++;
        checks++; if (alu_rob_num !== 6'd5) $display("FAIL basic_rob got %0d exp 5", alu_rob_num); else passed++;
        alu_iss_ready = 1'b1;
        step();
        alu_iss_ready = 1'b0;
        checks++; if (alu_iss !== 1'b0 || occupancy !== 3'd0)
            $display("FAIL basic_drain got iss=%b occ=%0d exp 0/0", alu_iss, occupancy); else passed++;
    endtask

    task automatic test_wakeup();
        dispatch(3'b001, 6'd8, 1'b0, 6'd7, 32'h0, 1'b1, 6'd0, 32'h5);
        checks++; if (alu_iss !== 1'b0) $display("FAIL wake_wait got %b exp 0", alu_iss); else passed++;
        wb_valid = 1'b1; wb_tag = 6'd7; wb_data = 32'hABCD;
        #1;
        checks++; if (alu_iss !== 1'b0) $display("FAIL wake_same_cycle got %b exp 0", alu_iss); else passed++;
        step();
        wb_valid = 1'b0;
        checks++; if (alu_iss !== 1'b1) $display("FAIL wake_iss got %b exp 1", alu_iss); else passed++;
        checks++; if (alu_data[31:0] !== 32'hABCD) $display("FAIL wake_data got %h exp abcd", alu_data[31:0]); else passed++;
        checks++; if (alu_data[63:32] !== 32'h5) $display("FAIL wake_src2 got %h exp 5", alu_data[63:32]); else passed++;
        alu_iss_ready = 1'b1;
        step();
        alu_iss_ready = 1'b0;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) dispatch(3'b011, 6'(10 + i), 1'b1, 6'd0, 32'(i), 1'b1, 6'd0, 32'h0);
        checks++; if (occupancy !== 3'd4) $display("FAIL full_occ got %0d exp 4", occupancy); else passed++;
        checks++; if (disp_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", disp_ready); else passed++;
        dispatch(3'b011, 6'd20, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
        checks++; if (occupancy !== 3'd4) $display("FAIL full_fifth got %0d exp 4", occupancy); else passed++;
        alu_iss_ready = 1'b1;
        #1;
        checks++; if (disp_ready !== 1'b0) $display("FAIL full_ready_issue_cycle got %b exp 0", disp_ready); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (alu_rob_num !== 6'(10 + i))
                $display("FAIL full_order%0d got %0d exp %0d", i, alu_rob_num, 10 + i); else passed++;
            step();
            if (i == 0) begin
                checks++; if (disp_ready !== 1'b1 || occupancy !== 3'd3)
                    $display("FAIL full_after_issue got rdy=%b occ=%0d exp 1/3", disp_ready, occupancy); else passed++;
            end
        end
        alu_iss_ready = 1'b0;
        checks++; if (alu_iss !== 1'b0 || occupancy !== 3'd0)
            $display("FAIL full_drain got iss=%b occ=%0d exp 0/0", alu_iss, occupancy); else passed++;
    endtask

    task automatic test_back_to_back();
        dispatch(3'b100, 6'd1, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h1);
        alu_iss_ready = 1'b1;
        dispatch(3'b100, 6'd2, 1'b1, 6'd0, 32'h2, 1'b1, 6'd0, 32'h2);
        alu_iss_ready = 1'b0;
        checks++; if (occupancy !== 3'd1) $display("FAIL b2b_occ got %0d exp 1", occupancy); else passed++;
        checks++; if (alu_rob_num !== 6'd2) $display("FAIL b2b_rob got %0d exp 2", alu_rob_num); else passed++;
        alu_iss_ready = 1'b1;
        step();
        alu_iss_ready = 1'b0;
    endtask

    task automatic test_select_order();
        logic [5:0] first_rob, second_rob;
`ifdef ALU_ISQ_AGE_SELECT_EN
        first_rob = 6'd9; second_rob = 6'd3;
`else
        first_rob = 6'd3; second_rob = 6'd9;
`endif
        dispatch(3'b000, 6'd1, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
        dispatch(3'b000, 6'd2, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
        dispatch(3'b000, 6'd9, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
        alu_iss_ready = 1'b1;
        step();
        step();
        alu_iss_ready = 1'b0;
        dispatch(3'b000, 6'd3, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
        checks++; if (occupancy !== 3'd2) $display("FAIL sel_occ got %0d exp 2", occupancy); else passed++;
        checks++; if (alu_rob_num !== first_rob)
            $display("FAIL sel_first got %0d exp %0d", alu_rob_num, first_rob); else passed++;
        alu_iss_ready = 1'b1;
        step();
        checks++; if (alu_rob_num !== second_rob)
            $display("FAIL sel_second got %0d exp %0d", alu_rob_num, second_rob); else passed++;
        step();
        alu_iss_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) dispatch(3'b101, 6'(4 + i), 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
        flush = 1'b1; alu_iss_ready = 1'b1;
        disp_valid = 1'b1; disp_rob_num = 6'd30; disp_src1_rdy = 1'b1; disp_src2_rdy = 1'b1;
        #1;
        checks++; if (alu_iss !== 1'b0 || alu_data !== 67'd0)
            $display("FAIL flush_iss got %b/%h exp 0/0", alu_iss, alu_data); else passed++;
        step();
        flush = 1'b0; disp_valid = 1'b0; alu_iss_ready = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd0 || alu_iss !== 1'b0 || disp_ready !== 1'b1)
            $display("FAIL flush_after got occ=%0d iss=%b rdy=%b exp 0/0/1", occupancy, alu_iss, disp_ready); else passed++;
    endtask

    task automatic test_dispatch_wakeup();
        wb_valid = 1'b1; wb_tag = 6'd12; wb_data = 32'h1234;
        dispatch(3'b110, 6'd15, 1'b1, 6'd0, 32'h77, 1'b0, 6'd12, 32'h0);
        wb_valid = 1'b0;
        checks++; if (alu_iss !== 1'b1 || alu_data[63:32] !== 32'h1234)
            $display("FAIL dwake got iss=%b src2=%h exp 1/1234", alu_iss, alu_data[63:32]); else passed++;
        alu_iss_ready = 1'b1;
        step();
        alu_iss_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        dispatch(3'b001, 6'd21, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
        dispatch(3'b001, 6'd22, 1'b0, 6'd40, 32'h0, 1'b1, 6'd0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd0 || alu_iss !== 1'b0 || disp_ready !== 1'b1)
            $display("FAIL rst_mid got occ=%0d iss=%b rdy=%b exp 0/0/1", occupancy, alu_iss, disp_ready); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_full();
        test_back_to_back();
        test_select_order();
        test_flush();
        test_dispatch_wakeup();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
